alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 47 ++++
 rtl/alu_exec_core.sv | 58 +++++
 rtl/alu_exec.sv | 159 +++++++++++++++
 tb/tb_alu_exec.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared widths, tag encoding and decoded-op encoding for the ALU execution unit.
// Branches take their offset from a separate immediate field latched at accept.
package alu_exec_pkg;

    localparam int SINST_W  = 6;
    localparam int REGTAG_W = 4;
    localparam int DWORD_W  = 32;
    localparam int ADDR_W   = 5;

    localparam logic [REGTAG_W-1:0] UNLOCKED = 4'hF;

    typedef enum logic [SINST_W-1:0] {
        OP_ADD   = 6'd0,
        OP_SUB   = 6'd1,
        OP_AND   = 6'd2,
        OP_OR    = 6'd3,
        OP_XOR   = 6'd4,
        OP_SLT   = 6'd5,
        OP_SLTU  = 6'd6,
        OP_SLL   = 6'd7,
        OP_SRL   = 6'd8,
        OP_SRA   = 6'd9,
        OP_LUI   = 6'd10,
        OP_AUIPC = 6'd11,
        OP_JAL   = 6'd12,
        OP_JALR  = 6'd13,
        OP_BEQ   = 6'd14,
        OP_BNE   = 6'd15,
        OP_BLT   = 6'd16,
        OP_BGE   = 6'd17,
        OP_BLTU  = 6'd18,
        OP_BGEU  = 6'd19
    } op_e;

    function automatic logic is_shift(input op_e op);
        return op inside {OP_SLL, OP_SRL, OP_SRA};
    endfunction

    function automatic logic is_branch(input op_e op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic is_jump(input op_e op);
        return op inside {OP_JAL, OP_JALR};
    endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU and branch-compare datapath; shifts are handled by the caller.
module alu_core
    import alu_exec_pkg::*;
(
    input  op_e                op,
    input  logic [DWORD_W-1:0] x,
    input  logic [DWORD_W-1:0] y,
    input  logic [DWORD_W-1:0] pc,
    input  logic [DWORD_W-1:0] imm,
    output logic [DWORD_W-1:0] result,
    output logic               taken,
    output logic [DWORD_W-1:0] target
);

    logic signed [DWORD_W-1:0] sx;
    logic signed [DWORD_W-1:0] sy;
    logic        [DWORD_W-1:0] jalr_sum;

    assign sx       = x;
    assign sy       = y;
    assign jalr_sum = x + y;

    always_comb begin
        result = '0;
        taken  = 1'b0;
        target = '0;
        case (op)
            OP_ADD:   result = x + y;
            OP_SUB:   result = x - y;
            OP_AND:   result = x & y;
            OP_OR:    result = x | y;
            OP_XOR:   result = x ^ y;
            OP_SLT:   result = {{(DWORD_W-1){1'b0}}, sx < sy};
            OP_SLTU:  result = {{(DWORD_W-1){1'b0}}, x < y};
            OP_LUI:   result = y;
            OP_AUIPC: result = pc + y;
            OP_JAL: begin
                result = pc + 32'd4;
                taken  = 1'b1;
                target = pc + y;
            end
            OP_JALR: begin
                result = pc + 32'd4;
                taken  = 1'b1;
                target = {jalr_sum[DWORD_W-1:1], 1'b0};
            end
            // Branches write nothing back; target is pc-relative regardless of outcome
            OP_BEQ:  begin taken = (x == y); target = pc + imm; end
            OP_BNE:  begin taken = (x != y); target = pc + imm; end
            OP_BLT:  begin taken = (sx < sy);  target = pc + imm; end
            OP_BGE:  begin taken = (sx >= sy); target = pc + imm; end
            OP_BLTU: begin taken = (x < y);    target = pc + imm; end
            OP_BGEU: begin taken = (x >= y);   target = pc + imm; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: holds one reservation-station entry, waits for operands,
// runs a bit-serial shifter when needed and broadcasts the result for one cycle.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rs_busy,
    input  logic [SINST_W-1:0]  rs_op,
    input  logic [REGTAG_W-1:0] rs_tagx,
    input  logic [REGTAG_W-1:0] rs_tagy,
    input  logic [REGTAG_W-1:0] rs_tagw,
    input  logic [DWORD_W-1:0]  rs_datax,
    input  logic [DWORD_W-1:0]  rs_datay,
    input  logic [DWORD_W-1:0]  rs_imm,
    input  logic [ADDR_W-1:0]   rs_target,
    input  logic [DWORD_W-1:0]  rs_pc,
    output logic                busy_alu,
    output logic [DWORD_W-1:0]  alu_data,
    output logic [REGTAG_W-1:0] alu_tag,
    output logic                alu_valid,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                br_valid,
    output logic                br_taken,
    output logic [DWORD_W-1:0]  br_target
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_BCAST} state_e;

    state_e               state, state_nxt;
    op_e                  op_q;
    logic [REGTAG_W-1:0]  tagw_q;
    logic [ADDR_W-1:0]    target_q;
    logic [DWORD_W-1:0]   pc_q;
    logic [DWORD_W-1:0]   imm_q;
    logic [DWORD_W-1:0]   sh_val;
    logic [4:0]           sh_cnt;
    logic                 opnd_ready;
    logic [DWORD_W-1:0]   core_result;
    logic                 core_taken;
    logic [DWORD_W-1:0]   core_target;
    logic [DWORD_W-1:0]   bcast_result;

    function automatic logic [DWORD_W-1:0] shift_one(input op_e op, input logic [DWORD_W-1:0] v);
        case (op)
            OP_SLL:  return {v[DWORD_W-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[DWORD_W-1:1]};
            default: return {v[DWORD_W-1], v[DWORD_W-1:1]};
        endcase
    endfunction

    // Operands come straight from the station each WAIT cycle so forwarded values are seen
    assign opnd_ready = (rs_tagx == UNLOCKED) && (rs_tagy == UNLOCKED);

    alu_core u_core (
        .op     (op_q),
        .x      (rs_datax),
        .y      (rs_datay),
        .pc     (pc_q),
        .imm    (imm_q),
        .result (core_result),
        .taken  (core_taken),
        .target (core_target)
    );

    always_comb begin
        bcast_result = core_result;
        if (state == S_SHIFT)
            bcast_result = shift_one(op_q, sh_val);
        else if (is_shift(op_q))
            bcast_result = rs_datax;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rs_busy) state_nxt = S_WAIT;
            S_WAIT: begin
                if (opnd_ready) begin
                    if (is_shift(op_q) && (rs_datay[4:0] != 5'd0))
                        state_nxt = S_SHIFT;
                    else
                        state_nxt = S_BCAST;
                end
            end
            S_SHIFT: if (sh_cnt == 5'd1) state_nxt = S_BCAST;
            S_BCAST: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    // Outputs are registered; strobes are raised only on the edge entering BCAST
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_alu  <= 1'b0;
            alu_data  <= '0;
            alu_tag   <= UNLOCKED;
            alu_valid <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else if (rdy) begin
            busy_alu  <= (state_nxt != S_IDLE);
            alu_valid <= 1'b0;
            alu_tag   <= UNLOCKED;
            wr_en     <= 1'b0;
            br_valid  <= 1'b0;
            if (state_nxt == S_BCAST) begin
                alu_valid <= 1'b1;
                alu_tag   <= tagw_q;
                alu_data  <= bcast_result;
                wr_addr   <= target_q;
                wr_en     <= (target_q != '0) && !is_branch(op_q);
                br_valid  <= is_branch(op_q) || is_jump(op_q);
                br_taken  <= core_taken;
                br_target <= core_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (rs_busy) begin
                        op_q     <= op_e'(rs_op);
                        tagw_q   <= rs_tagw;
                        target_q <= rs_target;
                        pc_q     <= rs_pc;
                        imm_q    <= rs_imm;
                    end
                end
                S_WAIT: begin
                    if (opnd_ready) begin
                        sh_val <= rs_datax;
                        sh_cnt <= rs_datay[4:0];
                    end
                end
                S_SHIFT: begin
                    sh_val <= shift_one(op_q, sh_val);
                    sh_cnt <= sh_cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, random transactions against a
// behavioural model, plus reset-mid-shift and rdy-freeze sequences.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rs_busy;
    logic [5:0]  rs_op;
    logic [3:0]  rs_tagx, rs_tagy, rs_tagw;
    logic [31:0] rs_datax, rs_datay, rs_imm, rs_pc;
    logic [4:0]  rs_target;
    logic        busy_alu, alu_valid, wr_en, br_valid, br_taken;
    logic [31:0] alu_data, br_target;
    logic [3:0]  alu_tag;
    logic [4:0]  wr_addr;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rs_busy(rs_busy), .rs_op(rs_op),
        .rs_tagx(rs_tagx), .rs_tagy(rs_tagy), .rs_tagw(rs_tagw),
        .rs_datax(rs_datax), .rs_datay(rs_datay), .rs_imm(rs_imm),
        .rs_target(rs_target), .rs_pc(rs_pc),
        .busy_alu(busy_alu), .alu_data(alu_data), .alu_tag(alu_tag),
        .alu_valid(alu_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] x, y, pc, imm;
        logic [3:0]  tagw;
        logic [4:0]  tgt;
        int          waitc;
        logic [31:0] e_data;
        logic        e_taken;
        logic [31:0] e_btgt;
        logic        e_wr;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tagw,
                                 input logic [4:0] tgt, input int waitc, input logic [31:0] e_data,
                                 input logic e_taken, input logic [31:0] e_btgt, input logic e_wr,
                                 input int e_lat);
        vec_t v;
        v.op = op; v.x = x; v.y = y; v.pc = pc; v.imm = imm; v.tagw = tagw; v.tgt = tgt;
        v.waitc = waitc; v.e_data = e_data; v.e_taken = e_taken; v.e_btgt = e_btgt;
        v.e_wr = e_wr; v.e_lat = e_lat;
        return v;
    endfunction

    // Behavioural reference: whole-word arithmetic straight from the op definitions
    function automatic vec_t model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tagw,
                                   input logic [4:0] tgt, input int waitc);
        logic [31:0] r, t, s;
        logic        tk;
        int          sh;
        r = 0; tk = 0; t = 0; sh = 0;
        case (op_e'(op))
            OP_ADD:   r = x + y;
            OP_SUB:   r = x - y;
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_XOR:   r = x ^ y;
            OP_SLT:   r = ($signed(x) < $signed(y)) ? 1 : 0;
            OP_SLTU:  r = (x < y) ? 1 : 0;
            OP_SLL:   begin r = x << y[4:0]; sh = int'(y[4:0]); end
            OP_SRL:   begin r = x >> y[4:0]; sh = int'(y[4:0]); end
            OP_SRA:   begin r = $signed(x) >>> y[4:0]; sh = int'(y[4:0]); end
            OP_LUI:   r = y;
            OP_AUIPC: r = pc + y;
            OP_JAL:   begin r = pc + 4; tk = 1; t = pc + y; end
            OP_JALR:  begin r = pc + 4; tk = 1; s = x + y; t = s & 32'hFFFF_FFFE; end
            OP_BEQ:   begin tk = (x == y); t = pc + imm; end
            OP_BNE:   begin tk = (x != y); t = pc + imm; end
            OP_BLT:   begin tk = ($signed(x) < $signed(y)); t = pc + imm; end
            OP_BGE:   begin tk = ($signed(x) >= $signed(y)); t = pc + imm; end
            OP_BLTU:  begin tk = (x < y); t = pc + imm; end
            OP_BGEU:  begin tk = (x >= y); t = pc + imm; end
            default:  ;
        endcase
        return mkv(op, x, y, pc, imm, tagw, tgt, waitc, r, tk, t,
                   (tgt != 0) && !is_branch(op_e'(op)), 2 + waitc + sh);
    endfunction

    task automatic run_txn(input vec_t v, input bit freeze);
        int  edges;
        bit  brop;
        brop      = is_branch(op_e'(v.op)) || is_jump(op_e'(v.op));
        rs_busy   = 1; rs_op = v.op; rs_tagw = v.tagw; rs_target = v.tgt;
        rs_pc     = v.pc; rs_imm = v.imm; rs_datay = v.y; rs_tagy = UNLOCKED;
        rs_tagx   = (v.waitc > 0) ? 4'h3 : UNLOCKED;
        rs_datax  = (v.waitc > 0) ? ~v.x : v.x;
        tick();
        edges = 1;
        chk("busy_accept", {31'b0, busy_alu}, 1);
        for (int i = 0; i < v.waitc; i++) begin
            chk("busy_wait", {31'b0, busy_alu}, 1);
            chk("valid_wait", {31'b0, alu_valid}, 0);
            tick();
            edges++;
        end
        rs_tagx  = UNLOCKED;
        rs_datax = v.x;
        while (!alu_valid && edges < 200) begin
            tick();
            edges++;
        end
        rs_busy = 0;
        chk("latency", edges, v.e_lat);
        chk("alu_data", alu_data, v.e_data);
        chk("alu_tag", {28'b0, alu_tag}, {28'b0, v.tagw});
        chk("wr_en", {31'b0, wr_en}, {31'b0, v.e_wr});
        chk("wr_addr", {27'b0, wr_addr}, {27'b0, v.tgt});
        chk("br_valid", {31'b0, br_valid}, {31'b0, brop});
        if (brop) begin
            chk("br_taken", {31'b0, br_taken}, {31'b0, v.e_taken});
            chk("br_target", br_target, v.e_btgt);
        end
        if (freeze) begin
            rdy = 0;
            repeat (3) begin
                tick();
                chk("frz_valid", {31'b0, alu_valid}, 1);
                chk("frz_busy", {31'b0, busy_alu}, 1);
                chk("frz_data", alu_data, v.e_data);
            end
            rdy = 1;
        end
        tick();
        chk("post_valid", {31'b0, alu_valid}, 0);
        chk("post_busy", {31'b0, busy_alu}, 0);
        chk("post_wr_en", {31'b0, wr_en}, 0);
        chk("post_br_valid", {31'b0, br_valid}, 0);
        chk("post_tag", {28'b0, alu_tag}, {28'b0, UNLOCKED});
    endtask

    vec_t tbl[14];
    vec_t rv;
    bit   seen;

    initial begin
        tbl[0]  = mkv(OP_ADD,  7, 5, 0, 0, 4'h2, 5'd3, 0, 12, 0, 0, 1, 2);
        tbl[1]  = mkv(OP_SUB,  1, 2, 0, 0, 4'h5, 5'd7, 4, 32'hFFFF_FFFF, 0, 0, 1, 6);
        tbl[2]  = mkv(OP_SRA,  32'h8000_0000, 4, 0, 0, 4'h1, 5'd4, 0, 32'hF800_0000, 0, 0, 1, 6);
        tbl[3]  = mkv(OP_BLT,  32'hFFFF_FFFF, 0, 32'h100, 32'h20, 4'h6, 5'd9, 0, 0, 1, 32'h120, 0, 2);
        tbl[4]  = mkv(OP_JAL,  0, 8, 32'h40, 0, 4'h7, 5'd0, 0, 32'h44, 1, 32'h48, 0, 2);
        tbl[5]  = mkv(OP_SLL,  32'h1234, 0, 0, 0, 4'h8, 5'd2, 0, 32'h1234, 0, 0, 1, 2);
        tbl[6]  = mkv(OP_JALR, 32'h1001, 4, 32'h200, 0, 4'h9, 5'd1, 0, 32'h204, 1, 32'h1004, 1, 2);
        tbl[7]  = mkv(OP_SLTU, 1, 32'hFFFF_FFFF, 0, 0, 4'hA, 5'd5, 0, 1, 0, 0, 1, 2);
        tbl[8]  = mkv(OP_SLT,  1, 32'hFFFF_FFFF, 0, 0, 4'hB, 5'd5, 1, 0, 0, 0, 1, 3);
        tbl[9]  = mkv(OP_BGEU, 5, 5, 32'h10, 32'h8, 4'hC, 5'd6, 0, 0, 1, 32'h18, 0, 2);
        tbl[10] = mkv(OP_BNE,  5, 5, 32'h10, 32'h8, 4'hD, 5'd6, 2, 0, 0, 32'h18, 0, 4);
        tbl[11] = mkv(OP_LUI,  0, 32'hABCD_E000, 0, 0, 4'h0, 5'd31, 0, 32'hABCD_E000, 0, 0, 1, 2);
        tbl[12] = mkv(OP_AUIPC, 0, 32'h2000, 32'h1000, 0, 4'h4, 5'd8, 0, 32'h3000, 0, 0, 1, 2);
        tbl[13] = mkv(OP_SRL,  32'hF000_0000, 31, 0, 0, 4'h3, 5'd10, 0, 1, 0, 0, 1, 33);

        rst = 1; rdy = 1; rs_busy = 0; rs_op = 0; rs_tagx = UNLOCKED; rs_tagy = UNLOCKED;
        rs_tagw = 0; rs_datax = 0; rs_datay = 0; rs_imm = 0; rs_target = 0; rs_pc = 0;
        tick(); tick();
        rst = 0;
        chk("rst_busy", {31'b0, busy_alu}, 0);
        chk("rst_valid", {31'b0, alu_valid}, 0);
        chk("rst_tag", {28'b0, alu_tag}, {28'b0, UNLOCKED});
        chk("rst_data", alu_data, 0);
        chk("rst_wr_en", {31'b0, wr_en}, 0);
        chk("rst_br_valid", {31'b0, br_valid}, 0);

        foreach (tbl[i]) run_txn(tbl[i], 1'b0);

        // Strobe must hold while rdy is low during BCAST
        run_txn(tbl[0], 1'b1);

        for (int n = 0; n < 40; n++) begin
            rv = model(6'($urandom_range(0, 19)), $urandom, $urandom, $urandom, $urandom,
                       4'($urandom_range(0, 14)), 5'($urandom_range(0, 31)),
                       int'($urandom_range(0, 3)));
            run_txn(rv, 1'b0);
        end

        // Reset mid-SHIFT, asserted together with rdy=0 to show reset wins
        rs_busy = 1; rs_op = OP_SRA; rs_tagx = UNLOCKED; rs_tagy = UNLOCKED; rs_tagw = 4'h2;
        rs_datax = 32'h8000_0000; rs_datay = 10; rs_target = 5'd3; rs_pc = 0; rs_imm = 0;
        tick();
        rs_busy = 0;
        tick(); tick(); tick();
        chk("shift_busy", {31'b0, busy_alu}, 1);
        rdy = 0; rst = 1;
        tick();
        chk("mid_rst_busy", {31'b0, busy_alu}, 0);
        chk("mid_rst_valid", {31'b0, alu_valid}, 0);
        chk("mid_rst_tag", {28'b0, alu_tag}, {28'b0, UNLOCKED});
        chk("mid_rst_data", alu_data, 0);
        chk("mid_rst_wr", {31'b0, wr_en}, 0);
        chk("mid_rst_wr_addr", {27'b0, wr_addr}, 0);
        chk("mid_rst_br", {29'b0, br_valid, br_taken, 1'b0}, 0);
        chk("mid_rst_br_target", br_target, 0);
        rst = 0; rdy = 1;
        seen = 0;
        repeat (15) begin
            tick();
            if (alu_valid || busy_alu) seen = 1;
        end
        chk("no_bcast_after_rst", {31'b0, seen}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
